srl_fifo65: RTL and testbench
=============================

Name: srl_fifo65

Overview:
- Streaming FIFO built on the adjustable-length SRL64E delay line: WIDTH parallel SRL64E instances hold up to 64 words, plus one output register, for 65 words total.
- It is the stage that drives the SRL: it generates D/CE/A, consumes Q into a registered output, and manages occupancy.
- Used for rate decoupling between DSP stages in the DCP6 datapath, e.g. decimator output to the host interface.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 18, data word width in bits; one SRL64E per bit.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RSTN  in  1  synchronous active-low reset.
- IDAT  in  WIDTH  input data word.
- IVLD  in  1  input word valid.
- IRDY  out  1  FIFO can accept a word this cycle.
- ODAT  out  WIDTH  output data word (registered).
- OVLD  out  1  ODAT holds a valid word.
- ORDY  in  1  downstream accepts ODAT this cycle.
- LEVEL  out  7  total words held, 0..65 (SRL count plus OVLD).

Behaviour:
- Reset is synchronous active-low, sampled on the CLK edge while RSTN=0:
  - cnt=0, OVLD=0, ODAT=0, IRDY=0 while RSTN=0.
  - SRL contents are not cleared; they are don't-care.
  - Reset mid-transfer discards all words; the first post-reset word appears at ODAT as if the FIFO were fresh.
- Internal SRL occupancy cnt: 7 bits, 0..64.
- IRDY = RSTN_q & (cnt != 64), where RSTN_q is the registered reset release. IRDY must not depend combinationally on ORDY or IVLD.
- Push: wr = IVLD & IRDY.
  - SRL CE=wr, D=IDAT; the new word enters SRL position 0 and older words shift by one.
  - IVLD while IRDY=0 is ignored; the word is not taken.
- SRL read address A = cnt-1 (6 bits), selecting the oldest word. A is don't-care when cnt=0.
- Output load: ld = (cnt != 0) & (~OVLD | ORDY).
  - On ld: ODAT <= SRL Q at address cnt-1 (sampled before the edge), OVLD <= 1.
  - When OVLD & ORDY and cnt=0: OVLD <= 0 and ODAT holds its last value.
  - When OVLD & ~ORDY: ODAT and OVLD hold.
- Count update: cnt <= cnt + wr - ld. Push and load in the same cycle leaves cnt unchanged. This is correct because the read samples Q at cnt-1 before the shift.
- No bypass path. Minimum latency from an accepted push into an empty FIFO to OVLD=1 is 2 cycles:
  - Edge 1: word written to SRL, cnt=1.
  - Edge 2: word loaded to ODAT.
- LEVEL = cnt + OVLD, combinational from registers.
- Full (cnt=64):
  - IRDY=0.
  - If ORDY=1 and OVLD=1, a load frees one SRL slot, and IRDY returns to 1 the following cycle.
- Ordering: strict FIFO; no word is dropped or duplicated under any IVLD/ORDY pattern.
- Throughput: one word per cycle sustained in and out when neither side stalls.

Test Plan:
- Reset then single word: RSTN low 3 cycles; IRDY=0 and OVLD=0 throughout. Release, push 0x155 at cycle 0 → OVLD=1 and ODAT=0x155 after the 2nd edge; LEVEL goes 1, 1. ORDY=1 → OVLD=0, LEVEL=0.
- Fill: ORDY=0, push 0..69 continuously → exactly 65 words accepted (0..64). IRDY=0 once cnt=64, LEVEL=65, ODAT=0. Then ORDY=1 → words drain in order 0..64 with no gaps; IRDY reasserts one cycle after the first load.
- Streaming: IVLD=1 and ORDY=1 every cycle with an incrementing pattern for 200 words → output sequence identical, 1 word/cycle after 2-cycle startup, LEVEL steady at 2.
- Random backpressure: IVLD and ORDY each random at 50% for 10000 cycles with scoreboard → no loss, duplication or reorder; LEVEL always equals the scoreboard depth; LEVEL never exceeds 65.
- Boundary at the SRL address wrap: hold cnt at 32 and 33 (crossing the A[5] mux boundary) with simultaneous push and pop → ODAT matches the scoreboard; cnt unchanged across those cycles.
- Reset mid-operation: with LEVEL=40, pulse RSTN low 1 cycle → next edge OVLD=0 and LEVEL=0. Then push 0x2AA → ODAT=0x2AA after 2 cycles; no stale word is ever emitted.

Source files
------------

// File: rtl/srl_fifo65_if.sv
// Streaming handshake bundle for srl_fifo65: upstream push side, downstream
// pop side and the occupancy readout. Clock and reset stay plain ports.
interface srl_fifo65_if #(
    parameter int WIDTH = 18
);
    logic [WIDTH-1:0] IDAT;
    logic             IVLD;
    logic             IRDY;
    logic [WIDTH-1:0] ODAT;
    logic             OVLD;
    logic             ORDY;
    logic [6:0]       LEVEL;

    // Producer/consumer view: drives the data in and the downstream ready.
    modport master (
        output IDAT,
        output IVLD,
        input  IRDY,
        input  ODAT,
        input  OVLD,
        output ORDY,
        input  LEVEL
    );

    // FIFO view.
    modport slave (
        input  IDAT,
        input  IVLD,
        output IRDY,
        output ODAT,
        output OVLD,
        input  ORDY,
        output LEVEL
    );
endinterface

// File: rtl/srl_fifo65.sv
// 65-word streaming FIFO: a 64-deep adjustable-length shift register (one
// SRL64E per data bit) plus one registered output stage. New words always
// enter SRL position 0; the oldest word sits at address cnt-1 and is moved
// into the output register whenever that register is empty or being taken.
module srl_fifo65 #(
    parameter int WIDTH = 18
) (
    input  logic            CLK,
    input  logic            RSTN,
    srl_fifo65_if.slave     s_if
);

    localparam logic [6:0] SRL_FULL  = 7'd64;
    localparam logic [6:0] SRL_EMPTY = 7'd0;

    // Shift-register storage. Deliberately never reset so it maps onto SRL
    // primitives; stale contents are unreachable because cnt is cleared.
    logic [WIDTH-1:0] srl_q [64];
    logic [WIDTH-1:0] srl_d [64];

    // Control and output registers.
    logic [6:0]       cnt_q;
    logic [6:0]       cnt_d;
    logic             ovld_q;
    logic             ovld_d;
    logic [WIDTH-1:0] odat_q;
    logic [WIDTH-1:0] odat_d;
    logic             rstn_q;

    // Combinational helpers.
    logic             irdy_s;
    logic             wr_s;
    logic             ld_s;
    logic [5:0]       rd_addr_s;
    logic [WIDTH-1:0] srl_dout_s;

    // Handshake qualifiers and SRL read port; IRDY depends only on registers.
    always_comb begin
        irdy_s     = rstn_q & (cnt_q != SRL_FULL);
        wr_s       = s_if.IVLD & irdy_s;
        ld_s       = (cnt_q != SRL_EMPTY) & (~ovld_q | s_if.ORDY);
        // cnt=64 wraps to address 63 through the 6-bit subtraction.
        rd_addr_s  = cnt_q[5:0] - 6'd1;
        srl_dout_s = srl_q[rd_addr_s];
    end

    // SRL shift: on a push every word moves up one position and IDAT enters at 0.
    always_comb begin
        srl_d = srl_q;
        if (wr_s) begin
            srl_d[0] = s_if.IDAT;
            for (int i = 1; i < 64; i++) begin
                srl_d[i] = srl_q[i-1];
            end
        end else begin
            srl_d = srl_q;
        end
    end

    // SRL storage register (clock-enable shift, no reset).
    always_ff @(posedge CLK) begin
        srl_q <= srl_d;
    end

    // Next occupancy and output-stage state. The read samples Q before the
    // shift, so a simultaneous push and load leaves cnt unchanged.
    always_comb begin
        cnt_d  = cnt_q + {6'd0, wr_s} - {6'd0, ld_s};
        ovld_d = ovld_q;
        odat_d = odat_q;
        if (ld_s) begin
            odat_d = srl_dout_s;
            ovld_d = 1'b1;
        end else if (ovld_q & s_if.ORDY) begin
            ovld_d = 1'b0;
            odat_d = odat_q;
        end else begin
            ovld_d = ovld_q;
            odat_d = odat_q;
        end
    end

    // Control/output registers with synchronous active-low reset; rstn_q
    // keeps IRDY low until the first edge after reset is released.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            rstn_q <= 1'b0;
            cnt_q  <= 7'd0;
            ovld_q <= 1'b0;
            odat_q <= '0;
        end else begin
            rstn_q <= 1'b1;
            cnt_q  <= cnt_d;
            ovld_q <= ovld_d;
            odat_q <= odat_d;
        end
    end

    assign s_if.IRDY  = irdy_s;
    assign s_if.ODAT  = odat_q;
    assign s_if.OVLD  = ovld_q;
    assign s_if.LEVEL = cnt_q + {6'd0, ovld_q};

endmodule

// File: tb/tb_srl_fifo65.sv
// Self-checking bench for srl_fifo65: directed scenarios followed by a
// randomized backpressure run, all compared against a queue-based model.
module tb_srl_fifo65;

    localparam int W = 18;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    srl_fifo65_if #(.WIDTH(W)) bus ();

    srl_fifo65 #(.WIDTH(W)) dut (
        .CLK  (clk),
        .RSTN (rstn),
        .s_if (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: every word held, oldest first; m_ovld says whether
    // the head currently sits in the output register.
    logic [W-1:0] mq[$];
    bit           m_ovld = 1'b0;
    bit           m_rel  = 1'b0;
    bit           m_push = 1'b0;
    bit           m_pop  = 1'b0;
    int           pops   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the rules, step, then compare DUT to the model.
    task automatic cyc();
        int           srl_n;
        bit           push;
        bit           ld;
        bit           pop;
        logic [W-1:0] wd;
        srl_n = mq.size() - int'(m_ovld);
        push  = (rstn === 1'b1) && (bus.IVLD === 1'b1) && m_rel && (srl_n != 64);
        ld    = (rstn === 1'b1) && (srl_n != 0) && (!m_ovld || bus.ORDY === 1'b1);
        pop   = (rstn === 1'b1) && m_ovld && (bus.ORDY === 1'b1);
        wd    = bus.IDAT;
        @(posedge clk);
        #1;
        if (rstn !== 1'b1) begin
            mq.delete();
            m_ovld = 1'b0;
            m_rel  = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(wd);
            m_ovld = ld ? 1'b1 : (pop ? 1'b0 : m_ovld);
            m_rel  = 1'b1;
        end
        m_push = push;
        m_pop  = pop;
        if (pop) pops++;
        chk("ovld", 32'(bus.OVLD), 32'(m_ovld));
        chk("irdy", 32'(bus.IRDY), 32'(m_rel && ((mq.size() - int'(m_ovld)) != 64)));
        chk("level", 32'(bus.LEVEL), 32'(mq.size()));
        if (m_ovld) begin
            chk("odat", 32'(bus.ODAT), 32'(mq[0]));
        end else if (rstn !== 1'b1) begin
            chk("odat_rst", 32'(bus.ODAT), 32'd0);
        end
    endtask

    initial begin
        int nxt;
        int n;

        bus.IVLD = 1'b0;
        bus.ORDY = 1'b0;
        bus.IDAT = '0;
        rstn     = 1'b0;

        // Reset held three cycles: IRDY and OVLD low, ODAT cleared.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_irdy", 32'(bus.IRDY), 32'd0);
            chk("rst_ovld", 32'(bus.OVLD), 32'd0);
        end
        rstn = 1'b1;
        cyc();
        chk("rel_irdy", 32'(bus.IRDY), 32'd1);

        // Single word: two-edge latency, LEVEL 1 then 1, then popped.
        bus.IVLD = 1'b1;
        bus.IDAT = 18'h00155;
        cyc();
        chk("sw_lvl1", 32'(bus.LEVEL), 32'd1);
        chk("sw_ovld1", 32'(bus.OVLD), 32'd0);
        bus.IVLD = 1'b0;
        cyc();
        chk("sw_lvl2", 32'(bus.LEVEL), 32'd1);
        chk("sw_ovld2", 32'(bus.OVLD), 32'd1);
        chk("sw_odat", 32'(bus.ODAT), 32'h155);
        bus.ORDY = 1'b1;
        cyc();
        chk("sw_pop_ovld", 32'(bus.OVLD), 32'd0);
        chk("sw_pop_lvl", 32'(bus.LEVEL), 32'd0);

        // Streaming: one word per cycle each way, LEVEL steady at 2.
        bus.IVLD = 1'b1;
        bus.ORDY = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            bus.IDAT = W'(k);
            cyc();
            if (k >= 2) begin
                chk("st_lvl", 32'(bus.LEVEL), 32'd2);
                chk("st_ovld", 32'(bus.OVLD), 32'd1);
                chk("st_odat", 32'(bus.ODAT), 32'(k - 1));
            end
        end
        bus.IVLD = 1'b0;
        cyc();
        chk("st_last", 32'(bus.ODAT), 32'd200);
        cyc();
        chk("st_empty", 32'(bus.LEVEL), 32'd0);

        // Fill with ORDY low: exactly 65 words are taken.
        bus.ORDY = 1'b0;
        nxt = 0;
        for (int i = 0; i < 80; i++) begin
            bus.IVLD = (nxt < 70);
            bus.IDAT = W'(nxt);
            cyc();
            if (m_push) nxt++;
        end
        chk("fill_acc", 32'(nxt), 32'd65);
        chk("fill_lvl", 32'(bus.LEVEL), 32'd65);
        chk("fill_irdy", 32'(bus.IRDY), 32'd0);
        chk("fill_odat", 32'(bus.ODAT), 32'd0);

        // Drain in order with no gaps; IRDY returns after the first load.
        bus.IVLD = 1'b0;
        bus.ORDY = 1'b1;
        for (int i = 0; i <= 64; i++) begin
            chk("drain_ovld", 32'(bus.OVLD), 32'd1);
            chk("drain_odat", 32'(bus.ODAT), 32'(i));
            cyc();
            if (i == 0) chk("drain_irdy", 32'(bus.IRDY), 32'd1);
        end
        chk("drain_empty", 32'(bus.LEVEL), 32'd0);

        // SRL address boundary: hold cnt at 32, then 33, pushing and popping.
        bus.ORDY = 1'b0;
        bus.IVLD = 1'b1;
        n = 0;
        while (mq.size() < 33 && n < 100) begin
            bus.IDAT = W'($urandom);
            cyc();
            n++;
        end
        chk("bnd_reach32", 32'(bus.LEVEL), 32'd33);
        bus.ORDY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.IDAT = W'($urandom);
            cyc();
            chk("bnd_lvl33", 32'(bus.LEVEL), 32'd33);
        end
        bus.ORDY = 1'b0;
        bus.IDAT = W'($urandom);
        cyc();
        bus.ORDY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.IDAT = W'($urandom);
            cyc();
            chk("bnd_lvl34", 32'(bus.LEVEL), 32'd34);
        end
        bus.IVLD = 1'b0;
        for (int i = 0; i < 40; i++) cyc();
        chk("bnd_empty", 32'(bus.LEVEL), 32'd0);

        // Reset mid-operation at LEVEL 40, then a fresh word.
        bus.ORDY = 1'b0;
        bus.IVLD = 1'b1;
        n = 0;
        while (mq.size() < 40 && n < 100) begin
            bus.IDAT = W'($urandom);
            cyc();
            n++;
        end
        chk("mr_lvl40", 32'(bus.LEVEL), 32'd40);
        rstn = 1'b0;
        cyc();
        chk("mr_ovld", 32'(bus.OVLD), 32'd0);
        chk("mr_lvl", 32'(bus.LEVEL), 32'd0);
        rstn     = 1'b1;
        bus.IVLD = 1'b0;
        cyc();
        bus.IVLD = 1'b1;
        bus.IDAT = 18'h002AA;
        cyc();
        chk("mr_lvl1", 32'(bus.LEVEL), 32'd1);
        bus.IVLD = 1'b0;
        cyc();
        chk("mr_odat", 32'(bus.ODAT), 32'h2AA);
        chk("mr_ovld1", 32'(bus.OVLD), 32'd1);
        bus.ORDY = 1'b1;
        cyc();
        chk("mr_gone", 32'(bus.OVLD), 32'd0);
        cyc();
        chk("mr_nostale", 32'(bus.OVLD), 32'd0);

        // Random backpressure on both sides against the model.
        for (int i = 0; i < 10000; i++) begin
            bus.IVLD = 1'($urandom_range(0, 1));
            bus.ORDY = 1'($urandom_range(0, 1));
            bus.IDAT = W'($urandom);
            cyc();
            chk("rnd_lvl_max", 32'(bus.LEVEL <= 7'd65), 32'd1);
        end
        bus.IVLD = 1'b0;
        bus.ORDY = 1'b1;
        for (int i = 0; i < 70; i++) cyc();
        chk("rnd_empty", 32'(bus.LEVEL), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
